// File: rtl/ecc_enc_pkg.sv
// Shared types and helpers for the pipelined SECDED (extended Hamming) encoder.
// Holds the per-beat mode encoding, the per-mode code geometry (N/K/P) and small
// constant-foldable helpers used by the encoder datapath.
package ecc_enc_pkg;

  typedef enum logic [1:0] {
    MODE_8   = 2'b00,
    MODE_16  = 2'b01,
    MODE_32  = 2'b10,
    MODE_RSV = 2'b11
  } mode_t;

  // Codeword width N, info width K, Hamming parity count P (overall bit excluded).
  localparam int unsigned N8  = 8;
  localparam int unsigned K8  = 4;
  localparam int unsigned P8  = 3;
  localparam int unsigned N16 = 16;
  localparam int unsigned K16 = 11;
  localparam int unsigned P16 = 4;
  localparam int unsigned N32 = 32;
  localparam int unsigned K32 = 26;
  localparam int unsigned P32 = 5;

  // Internal datapath is always sized for the widest code the encoder knows about.
  localparam int unsigned InfoMax = K32;
  localparam int unsigned CwMax   = N32;
  localparam int unsigned PMax    = P32;

  function automatic int unsigned cw_width(mode_t mode);
    case (mode)
      MODE_8:  return N8;
      MODE_16: return N16;
      MODE_32: return N32;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_legal(mode_t mode, int unsigned max_cw);
    return (mode != MODE_RSV) && (cw_width(mode) <= max_cw);
  endfunction

  function automatic logic [InfoMax-1:0] info_mask(mode_t mode);
    case (mode)
      MODE_8:  return {{(InfoMax - K8){1'b0}}, {K8{1'b1}}};
      MODE_16: return {{(InfoMax - K16){1'b0}}, {K16{1'b1}}};
      MODE_32: return {InfoMax{1'b1}};
      default: return '0;
    endcase
  endfunction

  // Hamming position of info bit idx: the idx-th non-power-of-two position >= 3.
  function automatic logic [PMax-1:0] info_pos(int unsigned idx);
    int unsigned seen;
    logic [PMax-1:0] pos_r;
    seen  = 0;
    pos_r = '0;
    for (int unsigned p = 3; p < CwMax; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (seen == idx) pos_r = PMax'(p);
        seen++;
      end
    end
    return pos_r;
  endfunction

endpackage

// File: rtl/ecc_parity_calc.sv
// Combinational SECDED codeword builder.
// info_i : info word, already masked to the mode's K bits (LSB = d0)
// mode_i : code mode; MODE_RSV yields an all-zero codeword
// cw_o   : systematic codeword {overall, p[P-1:0], info[K-1:0]}, zero above N
module ecc_parity_calc
  import ecc_enc_pkg::*;
(
  input  logic [InfoMax-1:0] info_i,
  input  mode_t              mode_i,
  output logic [CwMax-1:0]   cw_o
);

  // XOR of the Hamming positions of all set info bits: bit j of this is exactly pj.
  logic [PMax-1:0] syn;

  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < InfoMax; i++) begin
      if (info_i[i]) syn ^= info_pos(i);
    end
  end

  always_comb begin
    cw_o = '0;
    case (mode_i)
      MODE_8: begin
        cw_o[K8-1:0]  = info_i[K8-1:0];
        cw_o[K8+:P8]  = syn[P8-1:0];
        cw_o[N8-1]    = ^{info_i[K8-1:0], syn[P8-1:0]};
      end
      MODE_16: begin
        cw_o[K16-1:0] = info_i[K16-1:0];
        cw_o[K16+:P16] = syn[P16-1:0];
        cw_o[N16-1]   = ^{info_i[K16-1:0], syn[P16-1:0]};
      end
      MODE_32: begin
        cw_o[K32-1:0] = info_i[K32-1:0];
        cw_o[K32+:P32] = syn[P32-1:0];
        cw_o[N32-1]   = ^{info_i[K32-1:0], syn[P32-1:0]};
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/ecc_enc_pipe.sv
// Two-stage valid/ready SECDED encoder with per-beat mode select.
// clk_i/rst_ni          : clock (rising) and asynchronous active-low reset
// in_valid_i/in_ready_o : input handshake; data_in_i info word, work_mod_i[1:0] mode
// out_valid_o/out_ready_i : output handshake; data_out_o codeword, out_mode_o, out_err_o
// cnt_clr_i             : synchronous clear of enc_count_o
// enc_count_o           : saturating count of error-free codewords delivered
module ecc_enc_pipe
  import ecc_enc_pkg::*;
#(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  parameter int unsigned AMBA_WORD          = 32,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in_i,
  input  logic [AMBA_WORD-1:0]          work_mod_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out_o,
  output logic [1:0]                    out_mode_o,
  output logic                          out_err_o,
  input  logic                          cnt_clr_i,
  output logic [CNT_WIDTH-1:0]          enc_count_o
);

  mode_t              in_mode;
  logic [InfoMax-1:0] in_info;
  logic               unused_work_mod;
  logic               unused_cw;

  assign in_mode         = mode_t'(work_mod_i[1:0]);
  assign in_info         = InfoMax'(data_in_i);
  assign unused_work_mod = ^work_mod_i[AMBA_WORD-1:2];

  // Stage 1: masked info + mode
  logic               s1_v_q, s1_v_d;
  logic [InfoMax-1:0] s1_info_q, s1_info_d;
  mode_t              s1_mode_q, s1_mode_d;

  // Stage 2: codeword, mode, error flag
  logic                          s2_v_q, s2_v_d;
  logic [MAX_CODEWORD_WIDTH-1:0] s2_data_q, s2_data_d;
  mode_t                         s2_mode_q, s2_mode_d;
  logic                          s2_err_q, s2_err_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv;
  logic [CwMax-1:0] cw;
  logic             s1_legal;

  ecc_parity_calc u_parity_calc (
    .info_i (s1_info_q),
    .mode_i (s1_mode_q),
    .cw_o   (cw)
  );

  assign unused_cw = ^cw;
  assign s1_legal  = is_legal(s1_mode_q, MAX_CODEWORD_WIDTH);

  always_comb begin
    // A stage moves when it is empty or its contents leave this cycle; this lets
    // bubbles collapse and keeps full throughput under continuous ready.
    s2_adv = !s2_v_q || out_ready_i;
    s1_adv = !s1_v_q || s2_adv;

    s1_v_d    = s1_v_q;
    s1_info_d = s1_info_q;
    s1_mode_d = s1_mode_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_mode_d = s2_mode_q;
    s2_err_d  = s2_err_q;

    if (s1_adv) begin
      s1_v_d = in_valid_i;
      if (in_valid_i) begin
        s1_info_d = in_info & info_mask(in_mode);
        s1_mode_d = in_mode;
      end
    end

    // Stage 2 only reloads while advancing, so the output holds during a stall.
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = s1_legal ? MAX_CODEWORD_WIDTH'(cw) : '0;
        s2_mode_d = s1_mode_q;
        s2_err_d  = !s1_legal;
      end
    end

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (s2_v_q && out_ready_i && !s2_err_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q    <= 1'b0;
      s1_info_q <= '0;
      s1_mode_q <= MODE_8;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_mode_q <= MODE_8;
      s2_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_info_q <= s1_info_d;
      s1_mode_q <= s1_mode_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_mode_q <= s2_mode_d;
      s2_err_q  <= s2_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_v_q;
  assign data_out_o  = s2_data_q;
  assign out_mode_o  = s2_mode_q;
  assign out_err_o   = s2_err_q;
  assign enc_count_o = cnt_q;

endmodule
